// File: rtl/frv_masked_shfrot_issuer.sv
// frv_masked_shfrot_issuer: masks a plain shift request into two shares, drives the masked shfrot unit, returns result shares (optional MASKED_SHFROT_REFRESH_EN)
module frv_masked_shfrot_issuer #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [4:0]           req_shamt,
  input  logic [BIT_WIDTH-1:0] req_rs1,
  input  logic [BIT_WIDTH-1:0] rng_mask,
  input  logic [BIT_WIDTH-1:0] rng_pad,
  output logic                 sh_ena,
  output logic                 sh_slli,
  output logic                 sh_srli,
  output logic                 sh_rori,
  output logic [5:0]           sh_shamt,
  output logic [BIT_WIDTH-1:0] sh_s0,
  output logic [BIT_WIDTH-1:0] sh_s1,
  output logic [BIT_WIDTH-1:0] sh_rp0,
  input  logic [BIT_WIDTH-1:0] sh_r0,
  input  logic [BIT_WIDTH-1:0] sh_r1,
  input  logic                 sh_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BIT_WIDTH-1:0] rsp_s0,
  output logic [BIT_WIDTH-1:0] rsp_s1,
  output logic                 rsp_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef MASKED_SHFROT_REFRESH_EN
  typedef enum logic [1:0] {IDLE, BUSY, REFRESH, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
`endif
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [4:0] shamt_q;
  logic [BIT_WIDTH-1:0] s0_q, s1_q, r0_q, r1_q;
  logic slli_q, srli_q, rori_q, err_q, timeout;
  assign timeout   = cnt == CW'(TIMEOUT - 1);
  assign req_ready = state == IDLE;
  assign sh_ena    = state == BUSY;
  assign rsp_valid = state == RESP;
  assign sh_slli   = slli_q;
  assign sh_srli   = srli_q;
  assign sh_rori   = rori_q;
  assign sh_shamt  = {1'b0, shamt_q};
  assign sh_s0     = s0_q;
  assign sh_s1     = s1_q;
  assign sh_rp0    = rng_pad;
  assign rsp_s0    = r0_q;
  assign rsp_s1    = r1_q;
  assign rsp_err   = err_q;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next-state: a result beats a simultaneous timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? BUSY : IDLE;
`ifdef MASKED_SHFROT_REFRESH_EN
      BUSY:    state_nx = sh_ready ? REFRESH : timeout ? RESP : BUSY;
      REFRESH: state_nx = RESP;
`else
      BUSY:    state_nx = (sh_ready || timeout) ? RESP : BUSY;
`endif
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: operand split on accept, result capture/timeout in BUSY; ROL becomes ROR by -shamt
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      shamt_q <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      slli_q  <= 1'b0;
      srli_q  <= 1'b0;
      rori_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        cnt     <= '0;
        s0_q    <= rng_mask;
        s1_q    <= req_rs1 ^ rng_mask;
        slli_q  <= req_op == 2'b00;
        srli_q  <= req_op == 2'b01;
        rori_q  <= req_op[1];
        shamt_q <= req_op == 2'b11 ? 5'd0 - req_shamt : req_shamt;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (sh_ready) begin
        r0_q  <= sh_r0;
        r1_q  <= sh_r1;
        err_q <= 1'b0;
      end else if (timeout) begin
        r0_q  <= '0;
        r1_q  <= '0;
        err_q <= 1'b1;
      end
    end
`ifdef MASKED_SHFROT_REFRESH_EN
    else if (state == REFRESH) begin
      r0_q <= r0_q ^ rng_mask;
      r1_q <= r1_q ^ rng_mask;
    end
`endif
  end
endmodule
